// File: rtl/alloc_dor_multi_pkg.sv
// Shared flit format, port indices, route modes and DOR helper for the mesh input-port allocators.
`ifndef ALLOC_DOR_MULTI_DEFS
`define ALLOC_DOR_MULTI_DEFS
`define DATA_WIDTH 32
`define RTID_H     7
`define RTID_L     0
`define HEAD       2'b01
`define BODY       2'b00
`define TAIL       2'b10
`define P_XM       0
`define P_XP       1
`define P_YM       2
`define P_YP       3
`define P_LOC      4
`define RT_XY      1'b0
`define RT_YX      1'b1
`endif

package alloc_dor_multi_pkg;

    localparam int unsigned DEF_DATA_WIDTH = `DATA_WIDTH;
    localparam int unsigned RTID_H         = `RTID_H;
    localparam int unsigned RTID_L         = `RTID_L;
    localparam int unsigned COORD_W        = (RTID_H - RTID_L + 1) / 2;

    localparam logic [1:0] FT_TAIL = `TAIL;

    localparam logic [2:0] P_XM  = 3'(`P_XM);
    localparam logic [2:0] P_XP  = 3'(`P_XP);
    localparam logic [2:0] P_YM  = 3'(`P_YM);
    localparam logic [2:0] P_YP  = 3'(`P_YP);
    localparam logic [2:0] P_LOC = 3'(`P_LOC);

    localparam logic RT_YX = `RT_YX;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    // Dimension-order route: returns the output channel index for a destination.
    function automatic logic [2:0] dor_route(
        input logic [COORD_W-1:0] dst_x,
        input logic [COORD_W-1:0] dst_y,
        input logic [COORD_W-1:0] rtr_x,
        input logic [COORD_W-1:0] rtr_y,
        input logic               mode
    );
        logic [2:0] x_port;
        logic [2:0] y_port;
        logic       x_done;
        logic       y_done;
        x_done = (dst_x == rtr_x);
        y_done = (dst_y == rtr_y);
        x_port = (dst_x < rtr_x) ? P_XM : P_XP;
        y_port = (dst_y < rtr_y) ? P_YM : P_YP;
        if (mode == RT_YX) begin
            dor_route = !y_done ? y_port : (!x_done ? x_port : P_LOC);
        end else begin
            dor_route = !x_done ? x_port : (!y_done ? y_port : P_LOC);
        end
    endfunction

endpackage

// File: rtl/alloc_dor_multi_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head data is valid whenever empty is low.
module sync_fifo_fwft #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   wr_en,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_q;
    logic             push;
    logic             pop;

    // A full FIFO refuses writes even when a read frees a slot in the same cycle.
    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign push    = wr_en & ~full;
    assign pop     = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];
    assign count   = cnt_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/alloc_dor_multi.sv
// Input-port allocator: buffers flits, routes packets by DOR (XY/YX) with wormhole lock,
// and drops packets whose destination channel is masked off.
module alloc_dor_multi
    import alloc_dor_multi_pkg::*;
#(
    parameter int unsigned        DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned        FIFO_DEPTH  = 4,
    parameter int unsigned        NUM_OUT     = 5,
    parameter logic [NUM_OUT-1:0] OUT_MASK    = {NUM_OUT{1'b1}},
    parameter int unsigned        ROUTE_MODE  = 0,
    parameter int unsigned        ROUTER_ID_X = 0,
    parameter int unsigned        ROUTER_ID_Y = 0
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [DATA_WIDTH-1:0]         data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic [NUM_OUT-1:0]            out_valid_o,
    input  logic [NUM_OUT-1:0]            out_ready_i,
    output logic [NUM_OUT*DATA_WIDTH-1:0] out_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
    output logic                          lock_o,
    output logic                          drop_o,
    output logic [15:0]                   drop_cnt_o
);

    localparam int unsigned CH_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    logic [DATA_WIDTH-1:0] head;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  pop;
    logic                  head_valid;
    logic                  head_tail;
    logic [2:0]            route_idx;
    logic [NUM_OUT-1:0]    route_sel;
    logic                  route_ok;
    logic [NUM_OUT-1:0]    lock_sel;

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [CH_W-1:0]       chan_q;
    logic [CH_W-1:0]       chan_d;
    logic [15:0]           drop_cnt_q;

    sync_fifo_fwft #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_data (data_i),
        .wr_en   (valid_i),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_cnt_o)
    );

    assign ready_o    = ~fifo_full;
    assign head_valid = ~fifo_empty;
    assign head_tail  = (head[DATA_WIDTH-1 -: 2] == FT_TAIL);
    assign out_data_o = {NUM_OUT{head}};

    // Route decision on the head flit; only meaningful in IDLE.
    assign route_idx = dor_route(head[RTID_L+COORD_W +: COORD_W],
                                 head[RTID_L +: COORD_W],
                                 COORD_W'(ROUTER_ID_X),
                                 COORD_W'(ROUTER_ID_Y),
                                 (ROUTE_MODE != 0));
    assign route_sel = NUM_OUT'(1) << route_idx;
    assign route_ok  = |(OUT_MASK & route_sel);
    assign lock_sel  = NUM_OUT'(1) << chan_q;

    // Next state, channel lock, offer and pop decisions.
    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        out_valid_o = '0;
        pop         = 1'b0;
        drop_o      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (head_valid) begin
                    if (route_ok) begin
                        out_valid_o = route_sel;
                        if (|(out_ready_i & route_sel)) begin
                            pop    = 1'b1;
                            chan_d = CH_W'(route_idx);
                            if (!head_tail) begin
                                state_d = ST_FWD;
                            end
                        end
                    end else begin
                        pop    = 1'b1;
                        drop_o = 1'b1;
                        if (!head_tail) begin
                            state_d = ST_DROP;
                        end
                    end
                end
            end
            ST_FWD: begin
                if (head_valid) begin
                    out_valid_o = lock_sel;
                    if (|(out_ready_i & lock_sel)) begin
                        pop = 1'b1;
                        if (head_tail) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (head_valid) begin
                    pop = 1'b1;
                    if (head_tail) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            chan_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            if (drop_o && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign lock_o     = (state_q != ST_IDLE);
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_alloc_dor_multi.sv
// Scoreboard bench for alloc_dor_multi: three instances (XY, YX, masked) at router (2,2).
`timescale 1ns/1ps
module tb_alloc_dor_multi;

    localparam int DW = 32;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_TAIL = 2'b10;

    logic clk;
    logic rstn;

    logic [DW-1:0]   din  [3];
    logic            vin  [3];
    logic            rdy  [3];
    logic [4:0]      ov   [3];
    logic [4:0]      ordy [3];
    logic [5*DW-1:0] od   [3];
    logic [2:0]      cnt  [3];
    logic            lock [3];
    logic            drop [3];
    logic [15:0]     dcnt [3];

    typedef struct {
        int            dut;
        int            chan;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   drop_seen [3];
    logic          pend  [3][5];
    logic [DW-1:0] pdata [3][5];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alloc_dor_multi #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .NUM_OUT(5), .OUT_MASK(5'b11111),
                      .ROUTE_MODE(0), .ROUTER_ID_X(2), .ROUTER_ID_Y(2)) u_xy (
        .clk(clk), .rstn(rstn), .data_i(din[0]), .valid_i(vin[0]), .ready_o(rdy[0]),
        .out_valid_o(ov[0]), .out_ready_i(ordy[0]), .out_data_o(od[0]), .fifo_cnt_o(cnt[0]),
        .lock_o(lock[0]), .drop_o(drop[0]), .drop_cnt_o(dcnt[0]));

    alloc_dor_multi #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .NUM_OUT(5), .OUT_MASK(5'b11111),
                      .ROUTE_MODE(1), .ROUTER_ID_X(2), .ROUTER_ID_Y(2)) u_yx (
        .clk(clk), .rstn(rstn), .data_i(din[1]), .valid_i(vin[1]), .ready_o(rdy[1]),
        .out_valid_o(ov[1]), .out_ready_i(ordy[1]), .out_data_o(od[1]), .fifo_cnt_o(cnt[1]),
        .lock_o(lock[1]), .drop_o(drop[1]), .drop_cnt_o(dcnt[1]));

    alloc_dor_multi #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .NUM_OUT(5), .OUT_MASK(5'b10111),
                      .ROUTE_MODE(0), .ROUTER_ID_X(2), .ROUTER_ID_Y(2)) u_mk (
        .clk(clk), .rstn(rstn), .data_i(din[2]), .valid_i(vin[2]), .ready_o(rdy[2]),
        .out_valid_o(ov[2]), .out_ready_i(ordy[2]), .out_data_o(od[2]), .fifo_cnt_o(cnt[2]),
        .lock_o(lock[2]), .drop_o(drop[2]), .drop_cnt_o(dcnt[2]));

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] mk(input logic [1:0] t, input int x, input int y, input int pay);
        return {t, 22'(pay), 4'(x), 4'(y)};
    endfunction

    task automatic expect_flit(input int d, input int ch, input logic [DW-1:0] f, input int c);
        exp_t e;
        e.dut = d; e.chan = ch; e.data = f; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds valid until a cycle where ready is high, then lets that edge accept the flit.
    task automatic send(input int d, input logic [DW-1:0] f);
        int n;
        n = 0;
        din[d] = f;
        vin[d] = 1'b1;
        while (!rdy[d] && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: dut %0d ready stuck low, required high within 200 cycles", d);
        end else begin
            tick();
        end
        vin[d] = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every handshake, checks one-hot and offer stability.
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            for (int d = 0; d < 3; d++)
                for (int i = 0; i < 5; i++)
                    pend[d][i] <= 1'b0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (|ov[d]) chk("onehot", 64'($countones(ov[d]) <= 1), 64'(1));
                if (drop[d]) drop_seen[d] <= drop_seen[d] + 1;
                for (int i = 0; i < 5; i++) begin
                    if (pend[d][i]) begin
                        chk("hold_valid", 64'(ov[d][i]), 64'(1));
                        chk("hold_data", 64'(od[d][i*DW +: DW]), 64'(pdata[d][i]));
                    end
                    pend[d][i]  <= ov[d][i] & ~ordy[d][i];
                    pdata[d][i] <= od[d][i*DW +: DW];
                    if (ov[d][i] && ordy[d][i]) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL sb_unexpected: dut %0d chan %0d data %0h, required no flit", d, i, od[d][i*DW +: DW]);
                        end else begin
                            e = exp_q.pop_front();
                            chk("sb_dut", 64'(d), 64'(e.dut));
                            chk("sb_chan", 64'(i), 64'(e.chan));
                            chk("sb_data", 64'(od[d][i*DW +: DW]), 64'(e.data));
                            if (e.cyc >= 0) chk("sb_cycle", 64'(cyc), 64'(e.cyc));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded 100000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic [DW-1:0] f [6];
        for (int d = 0; d < 3; d++) begin
            din[d] = '0; vin[d] = 1'b0; ordy[d] = 5'b11111; drop_seen[d] = 0;
        end
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #1;
        chk("rst_valid", 64'(ov[0]), 64'(0));
        chk("rst_lock", 64'(lock[0]), 64'(0));
        chk("rst_cnt", 64'(cnt[0]), 64'(0));
        chk("rst_dcnt", 64'(dcnt[2]), 64'(0));
        tick();
        rstn = 1'b1;
        tick();
        chk("rst_ready", 64'(rdy[0]), 64'(1));

        // 1: XY packet to (3,1) leaves on X-plus at one flit per cycle
        f[0] = mk(T_HEAD, 3, 1, 'h101); f[1] = mk(T_BODY, 3, 1, 'h102);
        f[2] = mk(T_BODY, 3, 1, 'h103); f[3] = mk(T_TAIL, 3, 1, 'h104);
        c0 = cyc;
        for (int k = 0; k < 4; k++) expect_flit(0, 1, f[k], c0 + 1 + k);
        send(0, f[0]); chk("t1_lock_head", 64'(lock[0]), 64'(0));
        send(0, f[1]); chk("t1_lock_mid", 64'(lock[0]), 64'(1));
        send(0, f[2]);
        send(0, f[3]); chk("t1_lock_tail_pend", 64'(lock[0]), 64'(1));
        tick();
        chk("t1_lock_done", 64'(lock[0]), 64'(0));
        chk("t1_cnt", 64'(cnt[0]), 64'(0));

        // 2: YX packet to (3,1) goes Y-minus; mid-packet ids are ignored
        f[0] = mk(T_HEAD, 3, 1, 'h201); f[1] = mk(T_BODY, 0, 0, 'h202);
        f[2] = mk(T_BODY, 3, 3, 'h203); f[3] = mk(T_TAIL, 1, 3, 'h204);
        c0 = cyc;
        for (int k = 0; k < 4; k++) expect_flit(1, 2, f[k], c0 + 1 + k);
        for (int k = 0; k < 4; k++) send(1, f[k]);
        tick();
        chk("t2_lock_done", 64'(lock[1]), 64'(0));

        // 3: local channel stalled, FIFO fills to 4, then 6 flits drain in order
        ordy[0][4] = 1'b0;
        f[0] = mk(T_HEAD, 2, 2, 'h301);
        for (int k = 1; k < 5; k++) f[k] = mk(T_BODY, 2, 2, 'h301 + k);
        f[5] = mk(T_TAIL, 2, 2, 'h306);
        for (int k = 0; k < 6; k++) expect_flit(0, 4, f[k], -1);
        for (int k = 0; k < 4; k++) send(0, f[k]);
        chk("t3_cnt_full", 64'(cnt[0]), 64'(4));
        chk("t3_ready_low", 64'(rdy[0]), 64'(0));
        fork
            begin
                repeat (3) tick();
                ordy[0][4] = 1'b1;
            end
            begin
                send(0, f[4]);
                send(0, f[5]);
            end
        join
        repeat (6) tick();
        chk("t3_cnt_empty", 64'(cnt[0]), 64'(0));
        chk("t3_lock_done", 64'(lock[0]), 64'(0));

        // 4: Y-plus masked off -> whole packet dropped, then X-minus traffic forwarded
        send(2, mk(T_HEAD, 2, 3, 'h401));
        chk("t4_drop_now", 64'(drop[2]), 64'(1));
        send(2, mk(T_BODY, 2, 3, 'h402));
        chk("t4_drop_once", 64'(drop[2]), 64'(0));
        chk("t4_lock_drop", 64'(lock[2]), 64'(1));
        send(2, mk(T_TAIL, 2, 3, 'h403));
        tick();
        chk("t4_drained", 64'(cnt[2]), 64'(0));
        chk("t4_lock_idle", 64'(lock[2]), 64'(0));
        chk("t4_dcnt", 64'(dcnt[2]), 64'(1));
        chk("t4_drop_pulses", 64'(drop_seen[2]), 64'(1));
        f[0] = mk(T_HEAD, 1, 2, 'h404); f[1] = mk(T_TAIL, 1, 2, 'h405);
        c0 = cyc;
        expect_flit(2, 0, f[0], c0 + 1);
        expect_flit(2, 0, f[1], c0 + 2);
        send(2, f[0]); send(2, f[1]);
        tick();
        chk("t4_fwd_lock", 64'(lock[2]), 64'(0));

        // 5: single-flit packet to (0,2) then a packet to (2,0) back-to-back
        f[0] = mk(T_TAIL, 0, 2, 'h501); f[1] = mk(T_HEAD, 2, 0, 'h502); f[2] = mk(T_TAIL, 2, 0, 'h503);
        c0 = cyc;
        expect_flit(0, 0, f[0], c0 + 1);
        expect_flit(0, 2, f[1], c0 + 2);
        expect_flit(0, 2, f[2], c0 + 3);
        send(0, f[0]); chk("t5_lock_single", 64'(lock[0]), 64'(0));
        send(0, f[1]); chk("t5_lock_after_single", 64'(lock[0]), 64'(0));
        send(0, f[2]); chk("t5_lock_second", 64'(lock[0]), 64'(1));
        tick();
        chk("t5_lock_done", 64'(lock[0]), 64'(0));

        // 6: reset in the middle of a packet
        f[0] = mk(T_HEAD, 3, 2, 'h601); f[1] = mk(T_BODY, 3, 2, 'h602);
        c0 = cyc;
        expect_flit(0, 1, f[0], c0 + 1);
        send(0, f[0]); send(0, f[1]);
        rstn = 1'b0;
        #1;
        chk("t6_valid", 64'(ov[0]), 64'(0));
        chk("t6_lock", 64'(lock[0]), 64'(0));
        chk("t6_cnt", 64'(cnt[0]), 64'(0));
        chk("t6_dcnt", 64'(dcnt[2]), 64'(0));
        tick();
        rstn = 1'b1;
        tick();
        chk("t6_ready", 64'(rdy[0]), 64'(1));
        f[0] = mk(T_HEAD, 2, 2, 'h603); f[1] = mk(T_TAIL, 2, 2, 'h604);
        c0 = cyc;
        expect_flit(0, 4, f[0], c0 + 1);
        expect_flit(0, 4, f[1], c0 + 2);
        send(0, f[0]); send(0, f[1]);
        repeat (3) tick();
        chk("t6_lock_done", 64'(lock[0]), 64'(0));
        chk("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
